issue_hazard_ctrl: RTL and testbench
====================================

Name: issue_hazard_ctrl

Overview:
- In-order issue controller between the InstructionDecodeUnit/InstructionScheduleUnit and the ExecutionUnit.
- Tracks destination registers with outstanding writes in a scoreboard and stalls issue on RAW and WAW hazards.
- Holds issue while a multi-cycle EU operation is in flight.
- Drives PC/IF-ID write enables and the one-cycle wrong-path flush after a taken branch.

Parameters:
- REG_ADDR_W, 5, register index width.
- NUM_REGS, 32, architectural registers tracked (register 0 is never tracked).
- LAT_W, 4, width of the execution-latency field.
- STALL_CNT_W, 16, width of the stall statistics counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  synchronous reset, active-high (asserted = 1); sampled on the clk rising edge.
- iDecValid  in  1  decoded instruction present in decode stage.
- iRs  in  REG_ADDR_W  source register A.
- iRt  in  REG_ADDR_W  source register B.
- iRd  in  REG_ADDR_W  destination register.
- iUsesRs  in  1  instruction reads iRs.
- iUsesRt  in  1  instruction reads iRt.
- iWritesRd  in  1  instruction writes iRd.
- iLatency  in  LAT_W  EU cycles for this op; 0 is treated as 1.
- iBranchTaken  in  1  instruction is a branch/jump resolved taken.
- iWbValid  in  1  writeback of a register this cycle.
- iWbRd  in  REG_ADDR_W  writeback destination.
- oIssue  out  1  instruction issues to the EU this cycle.
- oPCWr  out  1  PC write enable.
- oIFIDWr  out  1  IF/ID pipeline register write enable.
- oFlush  out  1  discard the IF/ID contents (insert bubble).
- oEUBusy  out  1  multi-cycle op occupying the EU.
- oPending  out  NUM_REGS  scoreboard bit vector.
- oStallCount  out  STALL_CNT_W  saturating count of stall cycles.

Behaviour:
- States: RUN, EXEC_WAIT, FLUSH. Reset state is RUN.
- While resetn = 1:
  - State forced to RUN; pending = 0; busy counter = 0; oStallCount = 0.
  - Combinational outputs are forced: oIssue = 0, oPCWr = 0, oIFIDWr = 0, oFlush = 0, oEUBusy = 0.
- Hazard (combinational, using registered pending only; there is no same-cycle writeback bypass):
  - raw = (iUsesRs & pending[iRs]) | (iUsesRt & pending[iRt]).
  - waw = iWritesRd & pending[iRd].
  - pending[0] always reads 0.
- oIssue = iDecValid & (state == RUN) & ~raw & ~waw.
- stall = iDecValid & ~oIssue & (state != FLUSH).
- oPCWr = oIFIDWr = ~stall. Both are 1 in FLUSH so the bubble is loaded.
- oFlush = (state == FLUSH). oEUBusy = (state == EXEC_WAIT).
- Scoreboard update per cycle:
  - Writeback clear is applied first: iWbValid & iWbRd != 0 clears pending[iWbRd].
  - Issue set is applied second: oIssue & iWritesRd & iRd != 0 sets pending[iRd].
  - Set wins if both target the same register. This cannot occur legally because of the WAW check.
  - Writeback to a non-pending register is ignored.
- Transitions:
  - RUN, oIssue & iBranchTaken -> FLUSH. Branches are single-cycle; iLatency is ignored.
  - RUN, oIssue & eff_lat > 1 -> EXEC_WAIT, with cnt = eff_lat - 1.
  - RUN, otherwise -> RUN.
  - EXEC_WAIT: cnt decrements each cycle; when cnt == 1, next state is RUN. oEUBusy is therefore high for exactly eff_lat - 1 cycles following the issue cycle.
  - FLUSH -> RUN after exactly one cycle. No issue occurs in FLUSH even if iDecValid = 1.
- oStallCount increments on every stall cycle and saturates at 2^STALL_CNT_W - 1 (no wrap).
- Reset asserted mid-EXEC_WAIT or in FLUSH: next cycle is RUN with the scoreboard cleared. In-flight writebacks arriving after reset are ignored, because they target non-pending registers.

Test Plan:
- Back-to-back independent ops, e.g. add r3 then add r4 (latency 1), with iWbValid for r3 one cycle after issue:
  - oIssue = 1 on both cycles.
  - oPCWr = 1 throughout.
  - oPending[3] set then cleared.
  - oStallCount = 0.
- RAW: issue op writing r5; next op reads r5 (iUsesRs, iRs = 5); writeback of r5 at cycle +3:
  - oIssue = 0 and oPCWr = oIFIDWr = 0 for cycles +1..+3.
  - Issue at +4 (no bypass).
  - oStallCount = 3.
- Multi-cycle: issue with iLatency = 4, next op independent and valid:
  - oEUBusy = 1 for exactly 3 cycles; second op issues on the 4th cycle after the first.
  - oStallCount = 3.
  - Repeat with iLatency = 0; it must behave as latency 1 (no busy cycle).
- Taken branch: issue with iBranchTaken = 1 while the next instruction is valid:
  - Next cycle oFlush = 1, oIssue = 0, oPCWr = oIFIDWr = 1, and oStallCount is unchanged.
  - The cycle after returns to RUN and issues.
- WAW plus register 0:
  - Pending r7; op writing r7 stalls until iWbRd = 7; the op issues the following cycle.
  - Op writing r0 never sets oPending[0], and a later op reading r0 issues immediately.
- Reset mid-op:
  - Assert resetn = 1 during EXEC_WAIT (cnt = 2) with oPending = 0x0000_0020.
  - Next cycle: oEUBusy = 0, oPending = 0, oStallCount = 0, oIssue = 0, oPCWr = 0.
  - After deassertion a valid op issues immediately.
- Saturation: force 70000 consecutive stall cycles -> oStallCount holds at 0xFFFF.

Source files
------------

// File: rtl/issue_hazard_ctrl.sv
// In-order issue controller: scoreboard-based RAW/WAW hazard detection,
// multi-cycle execution hold, taken-branch wrong-path flush and stall statistics.
module issue_hazard_ctrl #(
  parameter int REG_ADDR_W  = 5,
  parameter int NUM_REGS    = 32,
  parameter int LAT_W       = 4,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   iDecValid,
  input  logic [REG_ADDR_W-1:0]  iRs,
  input  logic [REG_ADDR_W-1:0]  iRt,
  input  logic [REG_ADDR_W-1:0]  iRd,
  input  logic                   iUsesRs,
  input  logic                   iUsesRt,
  input  logic                   iWritesRd,
  input  logic [LAT_W-1:0]       iLatency,
  input  logic                   iBranchTaken,
  input  logic                   iWbValid,
  input  logic [REG_ADDR_W-1:0]  iWbRd,
  output logic                   oIssue,
  output logic                   oPCWr,
  output logic                   oIFIDWr,
  output logic                   oFlush,
  output logic                   oEUBusy,
  output logic [NUM_REGS-1:0]    oPending,
  output logic [STALL_CNT_W-1:0] oStallCount
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    EXEC_WAIT = 2'd1,
    FLUSH     = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_nextState;
  logic [LAT_W-1:0]       r_cnt;
  logic [LAT_W-1:0]       w_cntNext;
  logic [NUM_REGS-1:0]    r_pending;
  logic [NUM_REGS-1:0]    w_pendingNext;
  logic [NUM_REGS-1:0]    w_pendView;
  logic [STALL_CNT_W-1:0] r_stallCount;
  logic [LAT_W-1:0]       w_effLat;
  logic                   w_raw;
  logic                   w_waw;
  logic                   w_issue;
  logic                   w_stall;

  // Register 0 is hardwired and never reported as having an outstanding write.
  assign w_pendView = {r_pending[NUM_REGS-1:1], 1'b0};

  // A zero latency field means a single-cycle operation.
  assign w_effLat = (iLatency == '0) ? LAT_W'(1) : iLatency;

  // Hazards look only at the registered scoreboard; a same-cycle writeback does not unblock.
  always_comb begin
    w_raw = (iUsesRs & w_pendView[iRs]) | (iUsesRt & w_pendView[iRt]);
    w_waw = iWritesRd & w_pendView[iRd];
  end

  // Issue/stall decisions and pipeline enables; everything is held low while in reset.
  always_comb begin
    w_issue = ~resetn & iDecValid & (r_state == RUN) & ~w_raw & ~w_waw;
    w_stall = ~resetn & iDecValid & ~w_issue & (r_state != FLUSH);
    oIssue  = w_issue;
    oPCWr   = ~resetn & ~w_stall;
    oIFIDWr = ~resetn & ~w_stall;
    oFlush  = ~resetn & (r_state == FLUSH);
    oEUBusy = ~resetn & (r_state == EXEC_WAIT);
  end

  // Next state and remaining-busy counter.
  always_comb begin
    w_nextState = r_state;
    w_cntNext   = r_cnt;
    case (r_state)
      RUN: begin
        if (w_issue && iBranchTaken) begin
          w_nextState = FLUSH;
        end else if (w_issue && (w_effLat > LAT_W'(1))) begin
          w_nextState = EXEC_WAIT;
          w_cntNext   = w_effLat - LAT_W'(1);
        end
      end
      EXEC_WAIT: begin
        w_cntNext = r_cnt - LAT_W'(1);
        if (r_cnt <= LAT_W'(1)) begin
          w_nextState = RUN;
        end
      end
      FLUSH: begin
        w_nextState = RUN;
      end
      default: begin
        w_nextState = RUN;
      end
    endcase
  end

  // Scoreboard update: writeback clears first, then the issuing instruction sets its destination.
  always_comb begin
    w_pendingNext = r_pending;
    if (iWbValid && (iWbRd != '0)) begin
      w_pendingNext[iWbRd] = 1'b0;
    end
    if (w_issue && iWritesRd && (iRd != '0)) begin
      w_pendingNext[iRd] = 1'b1;
    end
    w_pendingNext[0] = 1'b0;
  end

  // State, scoreboard and saturating stall counter registers.
  always_ff @(posedge clk) begin
    if (resetn) begin
      r_state      <= RUN;
      r_cnt        <= '0;
      r_pending    <= '0;
      r_stallCount <= '0;
    end else begin
      r_state   <= w_nextState;
      r_cnt     <= w_cntNext;
      r_pending <= w_pendingNext;
      if (w_stall && (r_stallCount != '1)) begin
        r_stallCount <= r_stallCount + STALL_CNT_W'(1);
      end
    end
  end

  assign oPending    = r_pending;
  assign oStallCount = r_stallCount;

endmodule

// File: tb/tb_issue_hazard_ctrl.sv
// Scoreboard bench for issue_hazard_ctrl: stimulus pushes model expectations,
// a monitor pops and compares them each cycle.
module tb_issue_hazard_ctrl;

  logic        clk;
  logic        resetn;
  logic        iDecValid;
  logic [4:0]  iRs;
  logic [4:0]  iRt;
  logic [4:0]  iRd;
  logic        iUsesRs;
  logic        iUsesRt;
  logic        iWritesRd;
  logic [3:0]  iLatency;
  logic        iBranchTaken;
  logic        iWbValid;
  logic [4:0]  iWbRd;
  logic        oIssue;
  logic        oPCWr;
  logic        oIFIDWr;
  logic        oFlush;
  logic        oEUBusy;
  logic [31:0] oPending;
  logic [15:0] oStallCount;

  typedef struct {
    int          idx;
    bit          known;
    logic        issue;
    logic        pcwr;
    logic        flush;
    logic        busy;
    logic [31:0] pend;
    logic [15:0] stall;
  } exp_t;

  exp_t        expQ[$];
  int          checks   = 0;
  int          failures = 0;
  int          cycleNo  = 0;

  logic [31:0] mPending  = '0;
  int          mBusyLeft = 0;
  int          mStall    = 0;
  bit          mFlush    = 0;
  bit          mKnown    = 0;

  issue_hazard_ctrl dut (
    .clk(clk), .resetn(resetn), .iDecValid(iDecValid),
    .iRs(iRs), .iRt(iRt), .iRd(iRd),
    .iUsesRs(iUsesRs), .iUsesRt(iUsesRt), .iWritesRd(iWritesRd),
    .iLatency(iLatency), .iBranchTaken(iBranchTaken),
    .iWbValid(iWbValid), .iWbRd(iWbRd),
    .oIssue(oIssue), .oPCWr(oPCWr), .oIFIDWr(oIFIDWr), .oFlush(oFlush),
    .oEUBusy(oEUBusy), .oPending(oPending), .oStallCount(oStallCount)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cmp(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    cmp("oIssue",  e.idx, 32'(oIssue),  32'(e.issue));
    cmp("oPCWr",   e.idx, 32'(oPCWr),   32'(e.pcwr));
    cmp("oIFIDWr", e.idx, 32'(oIFIDWr), 32'(e.pcwr));
    cmp("oFlush",  e.idx, 32'(oFlush),  32'(e.flush));
    cmp("oEUBusy", e.idx, 32'(oEUBusy), 32'(e.busy));
    if (e.known) begin
      cmp("oPending",    e.idx, oPending,          e.pend);
      cmp("oStallCount", e.idx, 32'(oStallCount),  32'(e.stall));
    end
  endtask

  // Drive one cycle of inputs, predict the outputs from the behavioural model, advance the model.
  task automatic applyStimulus(input bit rst, input bit dec, input int rs, input int rt, input int rd,
                               input bit uRs, input bit uRt, input bit wRd, input int lat,
                               input bit br, input bit wbV, input int wbRd);
    exp_t e;
    bit   hazard;
    bit   busy;
    bit   issue;
    bit   stall;
    int   effLat;
    @(negedge clk);
    resetn = rst; iDecValid = dec; iRs = 5'(rs); iRt = 5'(rt); iRd = 5'(rd);
    iUsesRs = uRs; iUsesRt = uRt; iWritesRd = wRd; iLatency = 4'(lat);
    iBranchTaken = br; iWbValid = wbV; iWbRd = 5'(wbRd);
    e.idx = cycleNo; e.known = mKnown; e.pend = mPending; e.stall = 16'(mStall);
    if (rst) begin
      e.issue = 0; e.pcwr = 0; e.flush = 0; e.busy = 0;
      mPending = '0; mBusyLeft = 0; mFlush = 0; mStall = 0; mKnown = 1;
    end else begin
      busy   = (mBusyLeft > 0);
      hazard = (uRs && rs != 0 && mPending[rs] == 1'b1) ||
               (uRt && rt != 0 && mPending[rt] == 1'b1) ||
               (wRd && rd != 0 && mPending[rd] == 1'b1);
      issue  = dec && !busy && !mFlush && !hazard;
      stall  = dec && !issue && !mFlush;
      e.issue = issue; e.pcwr = !stall; e.flush = mFlush; e.busy = busy;
      if (wbV && wbRd != 0) mPending[wbRd] = 1'b0;
      if (issue && wRd && rd != 0) mPending[rd] = 1'b1;
      if (busy) mBusyLeft--;
      mFlush = issue && br;
      if (issue && !br) begin
        effLat    = (lat == 0) ? 1 : lat;
        mBusyLeft = effLat - 1;
      end
      if (stall && mStall < 65535) mStall++;
    end
    expQ.push_back(e);
    cycleNo++;
  endtask

  task automatic idle(input bit wbV, input int wbRd);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, wbV, wbRd);
  endtask

  // Monitor: compare the DUT against the oldest expectation just before each rising edge.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (expQ.size() > 0) checkOutput(expQ.pop_front());
    end
  end

  // Directed scenarios followed by randomized traffic.
  initial begin
    int pq[$];
    int wb;
    resetn = 1; iDecValid = 0; iRs = 0; iRt = 0; iRd = 0; iUsesRs = 0; iUsesRt = 0;
    iWritesRd = 0; iLatency = 0; iBranchTaken = 0; iWbValid = 0; iWbRd = 0;

    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);

    // Back-to-back independent ops with writeback of r3 one cycle after issue.
    applyStimulus(0, 1, 1, 2, 3, 1, 1, 1, 1, 0, 0, 0);
    applyStimulus(0, 1, 1, 2, 4, 1, 1, 1, 1, 0, 1, 3);
    idle(1, 4);

    // RAW on r5 with writeback at +3, issue at +4.
    applyStimulus(0, 1, 0, 0, 5, 0, 0, 1, 1, 0, 0, 0);
    applyStimulus(0, 1, 5, 0, 6, 1, 0, 1, 1, 0, 0, 0);
    applyStimulus(0, 1, 5, 0, 6, 1, 0, 1, 1, 0, 0, 0);
    applyStimulus(0, 1, 5, 0, 6, 1, 0, 1, 1, 0, 1, 5);
    applyStimulus(0, 1, 5, 0, 6, 1, 0, 1, 1, 0, 0, 0);
    idle(1, 6);

    // Multi-cycle latency 4 then latency 0.
    applyStimulus(0, 1, 0, 0, 8, 0, 0, 1, 4, 0, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 1, 2, 9, 1, 1, 1, 1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 10, 0, 0, 1, 0, 0, 1, 8);
    applyStimulus(0, 1, 1, 2, 11, 1, 1, 1, 1, 0, 1, 9);
    idle(1, 10);
    idle(1, 11);

    // Taken branch with a valid follower.
    applyStimulus(0, 1, 1, 2, 0, 1, 1, 0, 3, 1, 0, 0);
    applyStimulus(0, 1, 1, 2, 12, 1, 1, 1, 1, 0, 0, 0);
    applyStimulus(0, 1, 1, 2, 12, 1, 1, 1, 1, 0, 0, 0);
    idle(1, 12);

    // WAW on r7, then register 0 handling.
    applyStimulus(0, 1, 0, 0, 7, 0, 0, 1, 1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 7, 0, 0, 1, 1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 7, 0, 0, 1, 1, 0, 1, 7);
    applyStimulus(0, 1, 0, 0, 7, 0, 0, 1, 1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 1, 7);
    applyStimulus(0, 1, 0, 0, 13, 1, 1, 1, 1, 0, 0, 0);
    idle(1, 13);

    // Reset during EXEC_WAIT with r5 pending, then an immediate issue.
    applyStimulus(0, 1, 0, 0, 5, 0, 0, 1, 4, 0, 0, 0);
    idle(0, 0);
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 5);
    applyStimulus(0, 1, 5, 0, 14, 1, 0, 1, 1, 0, 0, 0);
    idle(1, 14);

    // Stall counter saturation.
    applyStimulus(0, 1, 0, 0, 9, 0, 0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 70000; i++) applyStimulus(0, 1, 9, 0, 0, 1, 0, 0, 1, 0, 0, 0);
    idle(1, 9);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);

    // Randomized traffic on a small register window to provoke hazards.
    for (int i = 0; i < 3000; i++) begin
      pq.delete();
      for (int r = 1; r < 32; r++) if (mPending[r] == 1'b1) pq.push_back(r);
      wb = (pq.size() > 0 && $urandom_range(0, 9) < 5) ? pq[$urandom_range(0, pq.size() - 1)]
                                                       : int'($urandom_range(0, 7));
      applyStimulus($urandom_range(0, 99) < 1, $urandom_range(0, 9) < 8,
                    $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                    $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                    $urandom_range(0, 5), $urandom_range(0, 99) < 15,
                    $urandom_range(0, 1), wb);
    end

    @(negedge clk);
    #6;
    checks++;
    if (expQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL queue_drain actual=%0d expected=0", expQ.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
